alu_rs: RTL and testbench

Reservation station directly upstream of the ALU. Accepts decoded ALU-class instructions from dispatch and holds them until both operands are available, snooping the ALU and LSB result buses for pending ROB tags. Each cycle it issues at most one ready entry, as registered operand/opcode outputs that drive the combinational ALU and tag its result for the ROB.

---
 rtl/alu_rs.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_rs.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station feeding the combinational ALU: holds dispatched ALU ops until both
// operands arrive from the ALU/LSB result buses, then issues the lowest-index ready entry.
module alu_rs #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,

    input  logic                 disp_valid,
    input  logic [4:0]           disp_alu_op,
    input  logic [31:0]          disp_vj,
    input  logic [31:0]          disp_vk,
    input  logic                 disp_qj_valid,
    input  logic                 disp_qk_valid,
    input  logic [ROB_WIDTH-1:0] disp_qj,
    input  logic [ROB_WIDTH-1:0] disp_qk,
    input  logic [31:0]          disp_addr,
    input  logic                 disp_inst_length,
    input  logic [ROB_WIDTH-1:0] disp_dest,
    output logic                 rs_full,

    input  logic                 cdb_alu_valid,
    input  logic [ROB_WIDTH-1:0] cdb_alu_tag,
    input  logic [31:0]          cdb_alu_value,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_lsb_tag,
    input  logic [31:0]          cdb_lsb_value,

    output logic                 alu_valid,
    output logic [31:0]          alu_op1,
    output logic [31:0]          alu_op2,
    output logic [31:0]          alu_addr,
    output logic [4:0]           alu_op,
    output logic                 alu_inst_length,
    output logic [ROB_WIDTH-1:0] alu_dest
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Per-entry state; flags are packed vectors, wide fields are unpacked arrays.
    logic [RS_SIZE-1:0]   busy_q, busy_d;
    logic [RS_SIZE-1:0]   qj_valid_q, qj_valid_d;
    logic [RS_SIZE-1:0]   qk_valid_q, qk_valid_d;
    logic [RS_SIZE-1:0]   len_q, len_d;
    logic [4:0]           op_q   [RS_SIZE];
    logic [4:0]           op_d   [RS_SIZE];
    logic [31:0]          vj_q   [RS_SIZE];
    logic [31:0]          vj_d   [RS_SIZE];
    logic [31:0]          vk_q   [RS_SIZE];
    logic [31:0]          vk_d   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_d   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_d   [RS_SIZE];
    logic [31:0]          addr_q [RS_SIZE];
    logic [31:0]          addr_d [RS_SIZE];
    logic [ROB_WIDTH-1:0] dest_q [RS_SIZE];
    logic [ROB_WIDTH-1:0] dest_d [RS_SIZE];

    logic                 alu_valid_q, alu_valid_d;
    logic [31:0]          alu_op1_q, alu_op1_d;
    logic [31:0]          alu_op2_q, alu_op2_d;
    logic [31:0]          alu_addr_q, alu_addr_d;
    logic [4:0]           alu_op_q, alu_op_d;
    logic                 alu_len_q, alu_len_d;
    logic [ROB_WIDTH-1:0] alu_dest_q, alu_dest_d;

    logic [RS_SIZE-1:0]   ready_vec;
    logic                 issue_found;
    logic [IDX_W-1:0]     issue_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 accept;

    logic                 new_qj_valid, new_qk_valid;
    logic [31:0]          new_vj, new_vk;

    assign ready_vec = busy_q & ~qj_valid_q & ~qk_valid_q;
    assign rs_full   = &busy_q;
    assign accept    = disp_valid & ~rs_full;

    // Lowest-index priority encoders; scanning downward leaves the smallest hit.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Same-cycle broadcast of a dispatching op's producer resolves it on entry.
    always_comb begin
        new_qj_valid = disp_qj_valid;
        new_vj       = disp_vj;
        if (disp_qj_valid) begin
            if (cdb_alu_valid && cdb_alu_tag == disp_qj) begin
                new_qj_valid = 1'b0;
                new_vj       = cdb_alu_value;
            end else if (cdb_lsb_valid && cdb_lsb_tag == disp_qj) begin
                new_qj_valid = 1'b0;
                new_vj       = cdb_lsb_value;
            end
        end
        new_qk_valid = disp_qk_valid;
        new_vk       = disp_vk;
        if (disp_qk_valid) begin
            if (cdb_alu_valid && cdb_alu_tag == disp_qk) begin
                new_qk_valid = 1'b0;
                new_vk       = cdb_alu_value;
            end else if (cdb_lsb_valid && cdb_lsb_tag == disp_qk) begin
                new_qk_valid = 1'b0;
                new_vk       = cdb_lsb_value;
            end
        end
    end

    // Entry next state: snoop, issue and dispatch touch disjoint concerns per entry.
    always_comb begin
        busy_d     = busy_q;
        qj_valid_d = qj_valid_q;
        qk_valid_d = qk_valid_q;
        len_d      = len_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        addr_d     = addr_q;
        dest_d     = dest_q;

        if (flush_in) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_valid_q[i]) begin
                    if (cdb_alu_valid && cdb_alu_tag == qj_q[i]) begin
                        vj_d[i]       = cdb_alu_value;
                        qj_valid_d[i] = 1'b0;
                    end else if (cdb_lsb_valid && cdb_lsb_tag == qj_q[i]) begin
                        vj_d[i]       = cdb_lsb_value;
                        qj_valid_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_valid_q[i]) begin
                    if (cdb_alu_valid && cdb_alu_tag == qk_q[i]) begin
                        vk_d[i]       = cdb_alu_value;
                        qk_valid_d[i] = 1'b0;
                    end else if (cdb_lsb_valid && cdb_lsb_tag == qk_q[i]) begin
                        vk_d[i]       = cdb_lsb_value;
                        qk_valid_d[i] = 1'b0;
                    end
                end
            end

            if (issue_found) begin
                busy_d[issue_idx] = 1'b0;
            end

            if (accept && free_found) begin
                busy_d[free_idx]     = 1'b1;
                op_d[free_idx]       = disp_alu_op;
                vj_d[free_idx]       = new_vj;
                vk_d[free_idx]       = new_vk;
                qj_valid_d[free_idx] = new_qj_valid;
                qk_valid_d[free_idx] = new_qk_valid;
                qj_d[free_idx]       = disp_qj;
                qk_d[free_idx]       = disp_qk;
                addr_d[free_idx]     = disp_addr;
                len_d[free_idx]      = disp_inst_length;
                dest_d[free_idx]     = disp_dest;
            end
        end
    end

    // Issue register: payload holds when nothing issues, only valid drops.
    always_comb begin
        alu_valid_d = issue_found & ~flush_in;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_addr_d  = alu_addr_q;
        alu_op_d    = alu_op_q;
        alu_len_d   = alu_len_q;
        alu_dest_d  = alu_dest_q;
        if (issue_found && !flush_in) begin
            alu_op1_d  = vj_q[issue_idx];
            alu_op2_d  = vk_q[issue_idx];
            alu_addr_d = addr_q[issue_idx];
            alu_op_d   = op_q[issue_idx];
            alu_len_d  = len_q[issue_idx];
            alu_dest_d = dest_q[issue_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            qj_valid_q  <= '0;
            qk_valid_q  <= '0;
            alu_valid_q <= 1'b0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_addr_q  <= '0;
            alu_op_q    <= '0;
            alu_len_q   <= 1'b0;
            alu_dest_q  <= '0;
        end else if (rdy_in) begin
            busy_q      <= busy_d;
            qj_valid_q  <= qj_valid_d;
            qk_valid_q  <= qk_valid_d;
            len_q       <= len_d;
            op_q        <= op_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            addr_q      <= addr_d;
            dest_q      <= dest_d;
            alu_valid_q <= alu_valid_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_addr_q  <= alu_addr_d;
            alu_op_q    <= alu_op_d;
            alu_len_q   <= alu_len_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu_valid       = alu_valid_q;
    assign alu_op1         = alu_op1_q;
    assign alu_op2         = alu_op2_q;
    assign alu_addr        = alu_addr_q;
    assign alu_op          = alu_op_q;
    assign alu_inst_length = alu_len_q;
    assign alu_dest        = alu_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, every cycle compared
// against a slot-list model of the station.
module tb_alu_rs;

    localparam int RS = 8;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid;
    logic [4:0]  disp_alu_op;
    logic [31:0] disp_vj, disp_vk, disp_addr;
    logic        disp_qj_valid, disp_qk_valid, disp_inst_length;
    logic [3:0]  disp_qj, disp_qk, disp_dest;
    logic        rs_full;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        alu_valid, alu_inst_length;
    logic [31:0] alu_op1, alu_op2, alu_addr;
    logic [4:0]  alu_op;
    logic [3:0]  alu_dest;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_rs #(.RS_SIZE(RS), .ROB_WIDTH(4)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_alu_op(disp_alu_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_addr(disp_addr),
        .disp_inst_length(disp_inst_length), .disp_dest(disp_dest), .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
        .alu_valid(alu_valid), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_addr(alu_addr),
        .alu_op(alu_op), .alu_inst_length(alu_inst_length), .alu_dest(alu_dest)
    );

    // Reference: a list of slots, each an instruction waiting on zero, one or two tags.
    typedef struct {
        bit          busy;
        bit [4:0]    op;
        bit [31:0]   vj, vk, addr;
        bit          wj, wk, len;
        bit [3:0]    qj, qk, dest;
    } slot_t;

    slot_t     m_slot [RS];
    bit        e_valid, e_len;
    bit [31:0] e_op1, e_op2, e_addr;
    bit [4:0]  e_op;
    bit [3:0]  e_dest;

    function automatic bit e_full();
        for (int i = 0; i < RS; i++) if (!m_slot[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Value produced for a tag this cycle, ALU bus taking precedence.
    function automatic bit bus_val(input bit [3:0] tag, output bit [31:0] val);
        val = '0;
        if (cdb_alu_valid && cdb_alu_tag == tag) begin val = cdb_alu_value; return 1'b1; end
        if (cdb_lsb_valid && cdb_lsb_tag == tag) begin val = cdb_lsb_value; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_step();
        int        pick, slot;
        bit        was_full;
        bit [31:0] v;
        if (rst_in) begin
            foreach (m_slot[i]) m_slot[i].busy = 1'b0;
            e_valid = 0; e_op1 = 0; e_op2 = 0; e_addr = 0; e_op = 0; e_len = 0; e_dest = 0;
            return;
        end
        if (!rdy_in) return;
        if (flush_in) begin
            foreach (m_slot[i]) m_slot[i].busy = 1'b0;
            e_valid = 1'b0;
            return;
        end
        was_full = e_full();
        pick = -1;
        for (int i = 0; i < RS; i++)
            if (pick < 0 && m_slot[i].busy && !m_slot[i].wj && !m_slot[i].wk) pick = i;
        e_valid = (pick >= 0);
        if (pick >= 0) begin
            e_op1 = m_slot[pick].vj; e_op2 = m_slot[pick].vk; e_addr = m_slot[pick].addr;
            e_op = m_slot[pick].op; e_len = m_slot[pick].len; e_dest = m_slot[pick].dest;
        end
        for (int i = 0; i < RS; i++) begin
            if (m_slot[i].busy && m_slot[i].wj && bus_val(m_slot[i].qj, v)) begin
                m_slot[i].vj = v; m_slot[i].wj = 1'b0;
            end
            if (m_slot[i].busy && m_slot[i].wk && bus_val(m_slot[i].qk, v)) begin
                m_slot[i].vk = v; m_slot[i].wk = 1'b0;
            end
        end
        if (disp_valid && !was_full) begin
            slot = -1;
            for (int i = 0; i < RS; i++) if (slot < 0 && !m_slot[i].busy) slot = i;
            m_slot[slot].busy = 1'b1;
            m_slot[slot].op = disp_alu_op; m_slot[slot].addr = disp_addr;
            m_slot[slot].len = disp_inst_length; m_slot[slot].dest = disp_dest;
            m_slot[slot].qj = disp_qj; m_slot[slot].qk = disp_qk;
            m_slot[slot].vj = disp_vj; m_slot[slot].wj = disp_qj_valid;
            m_slot[slot].vk = disp_vk; m_slot[slot].wk = disp_qk_valid;
            if (disp_qj_valid && bus_val(disp_qj, v)) begin m_slot[slot].vj = v; m_slot[slot].wj = 1'b0; end
            if (disp_qk_valid && bus_val(disp_qk, v)) begin m_slot[slot].vk = v; m_slot[slot].wk = 1'b0; end
        end
        if (pick >= 0) m_slot[pick].busy = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("alu_valid", 32'(alu_valid), 32'(e_valid));
        chk("rs_full", 32'(rs_full), 32'(e_full()));
        chk("alu_op1", alu_op1, e_op1);
        chk("alu_op2", alu_op2, e_op2);
        chk("alu_addr", alu_addr, e_addr);
        chk("alu_op", 32'(alu_op), 32'(e_op));
        chk("alu_len", 32'(alu_inst_length), 32'(e_len));
        chk("alu_dest", 32'(alu_dest), 32'(e_dest));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic clear_inputs();
        flush_in = 0; disp_valid = 0; disp_alu_op = 0; disp_vj = 0; disp_vk = 0;
        disp_qj_valid = 0; disp_qk_valid = 0; disp_qj = 0; disp_qk = 0;
        disp_addr = 0; disp_inst_length = 0; disp_dest = 0;
        cdb_alu_valid = 0; cdb_alu_tag = 0; cdb_alu_value = 0;
        cdb_lsb_valid = 0; cdb_lsb_tag = 0; cdb_lsb_value = 0;
    endtask

    task automatic set_disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjv, input logic [3:0] qj, input logic qkv,
                            input logic [3:0] qk, input logic [3:0] dest);
        disp_valid = 1; disp_alu_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj_valid = qjv; disp_qj = qj; disp_qk_valid = qkv; disp_qk = qk;
        disp_dest = dest; disp_addr = $urandom; disp_inst_length = 1'($urandom_range(0, 1));
    endtask

    task automatic bcast_alu(input logic [3:0] tag, input logic [31:0] val);
        cdb_alu_valid = 1; cdb_alu_tag = tag; cdb_alu_value = val;
    endtask

    task automatic bcast_lsb(input logic [3:0] tag, input logic [31:0] val);
        cdb_lsb_valid = 1; cdb_lsb_tag = tag; cdb_lsb_value = val;
    endtask

    initial begin
        clear_inputs();
        rdy_in = 1; rst_in = 1;
        tick(); tick();
        rst_in = 0;
        chk("reset_valid", 32'(alu_valid), 32'd0);
        chk("reset_full", 32'(rs_full), 32'd0);
        chk("reset_op1", alu_op1, 32'd0);

        // ADD with both operands ready: visible two cycles after dispatch, one cycle wide.
        set_disp(5'd0, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 4'd3);
        tick(); clear_inputs();
        tick();
        chk("add_valid", 32'(alu_valid), 32'd1);
        chk("add_op1", alu_op1, 32'd5);
        chk("add_op2", alu_op2, 32'd7);
        chk("add_dest", 32'(alu_dest), 32'd3);
        tick();
        chk("add_done", 32'(alu_valid), 32'd0);

        // SUB waiting on tag 2, woken by the LSB bus.
        set_disp(5'd1, 32'hdead, 32'd10, 1, 4'd2, 0, 4'd0, 4'd5);
        tick(); clear_inputs();
        tick();
        chk("sub_wait", 32'(alu_valid), 32'd0);
        bcast_lsb(4'd2, 32'd30);
        tick(); clear_inputs();
        chk("sub_snoop", 32'(alu_valid), 32'd0);
        tick();
        chk("sub_valid", 32'(alu_valid), 32'd1);
        chk("sub_op1", alu_op1, 32'd30);
        chk("sub_op2", alu_op2, 32'd10);
        tick();

        // Broadcast on the dispatch cycle itself.
        set_disp(5'd1, 32'hdead, 32'd1, 1, 4'd2, 0, 4'd0, 4'd6);
        bcast_lsb(4'd2, 32'd44);
        tick(); clear_inputs();
        tick();
        chk("byp_valid", 32'(alu_valid), 32'd1);
        chk("byp_op1", alu_op1, 32'd44);
        tick();

        // Fill all slots on tag 9, drop a ninth, then drain in slot order.
        for (int i = 0; i < RS; i++) begin
            set_disp(5'd2, 32'd0, 32'(i), 1, 4'd9, 0, 4'd0, 4'(i));
            tick();
        end
        chk("fill_full", 32'(rs_full), 32'd1);
        set_disp(5'd2, 32'd0, 32'd99, 1, 4'd9, 0, 4'd0, 4'd15);
        tick(); clear_inputs();
        chk("drop_full", 32'(rs_full), 32'd1);
        bcast_alu(4'd9, 32'h99);
        tick(); clear_inputs();
        for (int i = 0; i < RS; i++) begin
            tick();
            chk("drain_valid", 32'(alu_valid), 32'd1);
            chk("drain_dest", 32'(alu_dest), 32'(i));
            chk("drain_op1", alu_op1, 32'h99);
            if (i == 0) chk("drain_full", 32'(rs_full), 32'd0);
        end
        tick();
        chk("drain_end", 32'(alu_valid), 32'd0);

        // Same tag on both buses: ALU bus value wins.
        set_disp(5'd3, 32'd0, 32'd1, 1, 4'd4, 0, 4'd0, 4'd7);
        tick(); clear_inputs();
        bcast_alu(4'd4, 32'h11);
        bcast_lsb(4'd4, 32'h22);
        tick(); clear_inputs();
        tick();
        chk("dual_valid", 32'(alu_valid), 32'd1);
        chk("dual_op1", alu_op1, 32'h11);
        tick();

        // Flush three waiting entries together with a same-cycle dispatch.
        for (int i = 0; i < 3; i++) begin
            set_disp(5'd4, 32'd0, 32'd0, 1, 4'd12, 0, 4'd0, 4'(i));
            tick();
        end
        set_disp(5'd4, 32'd1, 32'd2, 0, 4'd0, 0, 4'd0, 4'd8);
        flush_in = 1;
        tick(); clear_inputs();
        chk("flush_valid", 32'(alu_valid), 32'd0);
        chk("flush_full", 32'(rs_full), 32'd0);
        tick();
        chk("flush_nodisp", 32'(alu_valid), 32'd0);
        bcast_alu(4'd12, 32'h12);
        tick(); clear_inputs();
        tick();
        chk("flush_quiet", 32'(alu_valid), 32'd0);

        // rdy_in low freezes outputs and ignores a matching broadcast.
        set_disp(5'd5, 32'h55, 32'd1, 0, 4'd0, 0, 4'd0, 4'd1);
        tick();
        set_disp(5'd5, 32'd0, 32'd2, 1, 4'd6, 0, 4'd0, 4'd2);
        tick(); clear_inputs();
        rdy_in = 0;
        bcast_alu(4'd6, 32'h66);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(alu_valid), 32'd1);
            chk("hold_op1", alu_op1, 32'h55);
        end
        rdy_in = 1; clear_inputs();
        tick();
        chk("hold_pend1", 32'(alu_valid), 32'd0);
        tick();
        chk("hold_pend2", 32'(alu_valid), 32'd0);
        bcast_alu(4'd6, 32'h66);
        tick(); clear_inputs();
        tick();
        chk("hold_wake", 32'(alu_valid), 32'd1);
        chk("hold_wake_op1", alu_op1, 32'h66);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            rdy_in = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0)
                set_disp(5'($urandom_range(0, 31)), $urandom, $urandom,
                         1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) != 0) bcast_alu(4'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 1) != 0) bcast_lsb(4'($urandom_range(0, 7)), $urandom);
            tick();
        end
        clear_inputs();
        rdy_in = 1;
        for (int n = 0; n < 10; n++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
